iguana_reg_ext_demux: RTL and testbench

// - Routes Cheshire's external register-bus port to NumSlv downstream reg slaves
//   (HyperBus PHY/chip config spaces and future peripherals) using a runtime rule table.
// - Generalises the single fixed HyperBus region to N slaves and N rules.
// - Adds a registered request/response cut, an error response for unmapped addresses,
//   and a per-transaction timeout watchdog.

---
 rtl/iguana_reg_ext_demux_pkg.sv | 54 +++++
 rtl/iguana_reg_ext_demux.sv | 145 ++++++++++++++
 tb/tb_iguana_reg_ext_demux.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iguana_reg_ext_demux_pkg.sv
// Reg-bus request/response/rule types, the default external register map and demux FSM states.
// The default map gives each HyperBus chip its own config window starting at the reg-out base.
package iguana_reg_ext_demux_pkg;

   localparam int unsigned RegAddrWidth       = 48;
   localparam int unsigned RegDataWidth       = 32;
   localparam int unsigned HyperBusNumPhys    = 1;
   localparam int unsigned HyperBusNumChips   = 2;
   localparam int unsigned IguanaRegExtNumSlv = HyperBusNumPhys * HyperBusNumChips;

   localparam logic [RegAddrWidth-1:0] RegOutHyperBusBase = 48'h1_0000_0000;
   localparam logic [RegAddrWidth-1:0] HyperBusChipSize   = 48'h800_0000;

   typedef struct packed {
      logic [31:0]             idx;
      logic [RegAddrWidth-1:0] start_addr;
      logic [RegAddrWidth-1:0] end_addr;
   } reg_rule_t;

   typedef struct packed {
      logic [RegAddrWidth-1:0]   addr;
      logic                      write;
      logic [RegDataWidth-1:0]   wdata;
      logic [RegDataWidth/8-1:0] wstrb;
      logic                      valid;
   } reg_req_t;

   typedef struct packed {
      logic [RegDataWidth-1:0] rdata;
      logic                    error;
      logic                    ready;
   } reg_rsp_t;

   typedef reg_rule_t [IguanaRegExtNumSlv-1:0] reg_ext_map_t;

   function automatic reg_ext_map_t gen_reg_ext_map();
      reg_ext_map_t m;
      for (int unsigned i = 0; i < IguanaRegExtNumSlv; i++) begin
         m[i].idx        = i;
         m[i].start_addr = RegOutHyperBusBase + RegAddrWidth'(i) * HyperBusChipSize;
         m[i].end_addr   = m[i].start_addr + HyperBusChipSize;
      end
      return m;
   endfunction

   localparam reg_ext_map_t IguanaRegExtMap = gen_reg_ext_map();

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_RESP
   } state_e;

endpackage

// File: rtl/iguana_reg_ext_demux.sv
// Rule-table demux of one reg-bus master onto NumSlv slaves through a registered cut.
// Latency: hit = 1 + slave stall + 1 cycles; miss answered 1 cycle after the request.
// Backpressure: one transaction in flight; a slave stalling TimeoutCycles is aborted with error.
module iguana_reg_ext_demux
   import iguana_reg_ext_demux_pkg::*;
#(
   parameter int unsigned NumSlv        = 2,
   parameter int unsigned NumRules      = 2,
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 1024,
   parameter type         reg_req_t     = iguana_reg_ext_demux_pkg::reg_req_t,
   parameter type         reg_rsp_t     = iguana_reg_ext_demux_pkg::reg_rsp_t,
   parameter type         rule_t        = iguana_reg_ext_demux_pkg::reg_rule_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  rule_t    [NumRules-1:0] addr_map_i,
   input  reg_req_t               slv_req_i,
   output reg_rsp_t               slv_rsp_o,
   output reg_req_t [NumSlv-1:0]  mst_req_o,
   input  reg_rsp_t [NumSlv-1:0]  mst_rsp_i,
   output logic                   decode_err_o,
   output logic                   timeout_o
);

   localparam int unsigned IdxW = (NumSlv > 1) ? $clog2(NumSlv) : 1;
   localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);
   localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

   state_e                 state_q, state_d;
   reg_req_t               req_q;
   logic [IdxW-1:0]        idx_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   err_q;
   logic [CntW-1:0]        cnt_q;

   logic [AddrWidth-1:0]   dec_addr;
   logic                   dec_found;
   logic                   dec_hit;
   logic [IdxW-1:0]        dec_idx;
   reg_rsp_t               sel_rsp;
   logic                   limit;

   assign dec_addr = slv_req_i.addr;
   assign sel_rsp  = mst_rsp_i[idx_q];
   assign limit    = (TimeoutCycles != 0) && (cnt_q == CntLimit);

   // First matching rule decides; an out-of-range slave index in that rule is a miss.
   always_comb begin
      dec_found = 1'b0;
      dec_hit   = 1'b0;
      dec_idx   = '0;
      for (int unsigned r = 0; r < NumRules; r++) begin
         if (!dec_found && dec_addr >= addr_map_i[r].start_addr &&
             dec_addr < addr_map_i[r].end_addr) begin
            dec_found = 1'b1;
            if (addr_map_i[r].idx < NumSlv) begin
               dec_hit = 1'b1;
               dec_idx = IdxW'(addr_map_i[r].idx);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (slv_req_i.valid) state_d = dec_hit ? ST_FWD : ST_RESP;
         ST_FWD:  if (sel_rsp.ready || limit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         req_q        <= '0;
         idx_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         decode_err_o <= 1'b0;
         timeout_o    <= 1'b0;
      end else begin
         decode_err_o <= 1'b0;
         timeout_o    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (slv_req_i.valid) begin
                  req_q <= slv_req_i;
                  idx_q <= dec_idx;
                  cnt_q <= '0;
                  if (!dec_hit) begin
                     rdata_q      <= '0;
                     err_q        <= 1'b1;
                     decode_err_o <= 1'b1;
                  end
               end
            end
            ST_FWD: begin
               // A response arriving on the limit cycle still completes normally.
               if (sel_rsp.ready) begin
                  rdata_q <= req_q.write ? '0 : sel_rsp.rdata;
                  err_q   <= sel_rsp.error;
               end else if (limit) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  timeout_o <= 1'b1;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            ST_RESP: cnt_q <= '0;
            default: cnt_q <= '0;
         endcase
      end
   end

   always_comb begin
      for (int unsigned s = 0; s < NumSlv; s++) begin
         mst_req_o[s] = '0;
         if (state_q == ST_FWD && idx_q == IdxW'(s)) begin
            mst_req_o[s]       = req_q;
            mst_req_o[s].valid = 1'b1;
         end
      end
   end

   always_comb begin
      slv_rsp_o = '0;
      if (state_q == ST_RESP) begin
         slv_rsp_o.ready = 1'b1;
         slv_rsp_o.rdata = rdata_q;
         slv_rsp_o.error = err_q;
      end
   end

endmodule

// File: tb/tb_iguana_reg_ext_demux.sv
// Bench for iguana_reg_ext_demux: directed scenarios plus randomized transactions
// checked against a transaction-level model of decode, latency and timeout.
module tb_iguana_reg_ext_demux;
   import iguana_reg_ext_demux_pkg::*;

   localparam int T = 16;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          v0;
      int          v1;
      int          dec;
      int          to;
      int          bad;
   } txn_res_t;

   logic                clk = 1'b0;
   logic                rst;
   reg_rule_t [1:0]     addr_map;
   reg_req_t            slv_req;
   reg_rsp_t            slv_rsp;
   reg_req_t  [1:0]     mst_req;
   reg_rsp_t  [1:0]     mst_rsp;
   logic                decode_err;
   logic                timeout;

   int vectors     = 0;
   int miscompares = 0;

   iguana_reg_ext_demux #(
      .NumSlv(2), .NumRules(2), .AddrWidth(48), .DataWidth(32), .TimeoutCycles(T),
      .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t), .rule_t(reg_rule_t)
   ) dut (
      .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map),
      .slv_req_i(slv_req), .slv_rsp_o(slv_rsp),
      .mst_req_o(mst_req), .mst_rsp_i(mst_rsp),
      .decode_err_o(decode_err), .timeout_o(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic set_default_map();
      addr_map[0].idx = 0; addr_map[0].start_addr = 48'h1_0000_0000; addr_map[0].end_addr = 48'h1_0800_0000;
      addr_map[1].idx = 1; addr_map[1].start_addr = 48'h1_0800_0000; addr_map[1].end_addr = 48'h1_1000_0000;
   endtask

   // Reference: first rule containing the address picks the slave; bad index or no rule is a miss.
   function automatic int model_target(input logic [47:0] a);
      for (int r = 0; r < 2; r++)
         if (a >= addr_map[r].start_addr && a < addr_map[r].end_addr)
            return (addr_map[r].idx < 2) ? int'(addr_map[r].idx) : -1;
      return -1;
   endfunction

   function automatic txn_res_t model_txn(input int tgt, input logic wr, input int stall,
                                          input logic [31:0] srd, input logic serr);
      txn_res_t e;
      e.bad = 0; e.v0 = 0; e.v1 = 0; e.dec = 0; e.to = 0;
      if (tgt < 0) begin
         e.lat = 1; e.rdata = 0; e.err = 1; e.dec = 1;
      end else if (stall >= T) begin
         e.lat = T + 1; e.rdata = 0; e.err = 1; e.to = 1;
         if (tgt == 0) e.v0 = T; else e.v1 = T;
      end else begin
         e.lat = stall + 2; e.rdata = wr ? 32'h0 : srd; e.err = serr;
         if (tgt == 0) e.v0 = stall + 1; else e.v1 = stall + 1;
      end
      return e;
   endfunction

   // Drives one request held until the response; the addressed slave raises ready after
   // 'stall' cycles of valid, the other slave answers ready with junk at all times.
   task automatic run_txn(input logic [47:0] a, input logic wr, input logic [31:0] wd,
                          input logic [3:0] ws, input int tgt, input int stall,
                          input logic [31:0] srd, input logic serr, output txn_res_t r);
      r.lat = -1; r.rdata = 0; r.err = 0; r.v0 = 0; r.v1 = 0; r.dec = 0; r.to = 0; r.bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         slv_req.addr = a; slv_req.write = wr; slv_req.wdata = wd;
         slv_req.wstrb = ws; slv_req.valid = 1'b1;
         for (int k = 0; k < 2; k++) begin
            if (k == tgt) begin
               mst_rsp[k].ready = (c >= 1 + stall); mst_rsp[k].rdata = srd; mst_rsp[k].error = serr;
            end else begin
               mst_rsp[k].ready = 1'b1; mst_rsp[k].rdata = ~srd; mst_rsp[k].error = 1'b1;
            end
         end
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (mst_req[k].valid === 1'b1) begin
               if (k == 0) r.v0++; else r.v1++;
               if (mst_req[k].addr !== a || mst_req[k].write !== wr ||
                   mst_req[k].wdata !== wd || mst_req[k].wstrb !== ws) r.bad++;
            end
         end
         if (decode_err === 1'b1) r.dec++;
         if (timeout === 1'b1) r.to++;
         if (slv_rsp.ready === 1'b1) begin
            r.lat = c; r.rdata = slv_rsp.rdata; r.err = slv_rsp.error;
            break;
         end
      end
   endtask

   task automatic go_idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         slv_req = '0; mst_rsp = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; slv_req = '0; mst_rsp = '0; set_default_map();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors += 5;
      if (slv_rsp !== '0) begin miscompares++; $display("FAIL reset_slv_rsp got %h exp 0", slv_rsp); end
      if (mst_req[0].valid !== 1'b0) begin miscompares++; $display("FAIL reset_mst0_valid got %b exp 0", mst_req[0].valid); end
      if (mst_req[1].valid !== 1'b0) begin miscompares++; $display("FAIL reset_mst1_valid got %b exp 0", mst_req[1].valid); end
      if (decode_err !== 1'b0) begin miscompares++; $display("FAIL reset_decode_err got %b exp 0", decode_err); end
      if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b exp 0", timeout); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_read_hit();
      txn_res_t r;
      run_txn(48'h1_0000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 1'b0, r);
      go_idle(1);
      vectors += 5;
      if (r.lat !== 2) begin miscompares++; $display("FAIL read_hit_lat got %0d exp 2", r.lat); end
      if (r.rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL read_hit_rdata got %h exp cafef00d", r.rdata); end
      if (r.err !== 1'b0) begin miscompares++; $display("FAIL read_hit_err got %b exp 0", r.err); end
      if (r.v0 !== 1 || r.bad !== 0) begin miscompares++; $display("FAIL read_hit_mst0 got v=%0d bad=%0d exp v=1 bad=0", r.v0, r.bad); end
      if (r.v1 !== 0) begin miscompares++; $display("FAIL read_hit_mst1 got %0d exp 0", r.v1); end
   endtask

   task automatic test_write_stall();
      txn_res_t r;
      run_txn(48'h1_0800_0004, 1'b1, 32'h1234_5678, 4'hF, 1, 5, 32'hDEAD_BEEF, 1'b0, r);
      go_idle(1);
      vectors += 5;
      if (r.v1 !== 6 || r.bad !== 0) begin miscompares++; $display("FAIL write_mst1 got v=%0d bad=%0d exp v=6 bad=0", r.v1, r.bad); end
      if (r.v0 !== 0) begin miscompares++; $display("FAIL write_mst0 got %0d exp 0", r.v0); end
      if (r.lat !== 7) begin miscompares++; $display("FAIL write_lat got %0d exp 7", r.lat); end
      if (r.rdata !== 32'h0) begin miscompares++; $display("FAIL write_rdata got %h exp 0", r.rdata); end
      if (r.err !== 1'b0) begin miscompares++; $display("FAIL write_err got %b exp 0", r.err); end
   endtask

   task automatic test_miss();
      txn_res_t r;
      run_txn(48'h2_0000_0000, 1'b0, 32'h0, 4'h0, -1, 0, 32'h5555_AAAA, 1'b0, r);
      go_idle(1);
      vectors += 5;
      if (r.lat !== 1) begin miscompares++; $display("FAIL miss_lat got %0d exp 1", r.lat); end
      if (r.err !== 1'b1) begin miscompares++; $display("FAIL miss_err got %b exp 1", r.err); end
      if (r.rdata !== 32'h0) begin miscompares++; $display("FAIL miss_rdata got %h exp 0", r.rdata); end
      if (r.dec !== 1) begin miscompares++; $display("FAIL miss_decode_err got %0d pulses exp 1", r.dec); end
      if (r.v0 + r.v1 !== 0) begin miscompares++; $display("FAIL miss_mst_valid got %0d exp 0", r.v0 + r.v1); end
   endtask

   task automatic test_timeout();
      txn_res_t r;
      run_txn(48'h1_0000_0100, 1'b0, 32'h0, 4'h0, 0, 1000, 32'h1111_2222, 1'b0, r);
      vectors += 5;
      if (r.v0 !== T) begin miscompares++; $display("FAIL timeout_mst0_valid got %0d exp %0d", r.v0, T); end
      if (r.lat !== T + 1) begin miscompares++; $display("FAIL timeout_lat got %0d exp %0d", r.lat, T + 1); end
      if (r.err !== 1'b1 || r.rdata !== 32'h0) begin miscompares++; $display("FAIL timeout_rsp got err=%b rdata=%h exp err=1 rdata=0", r.err, r.rdata); end
      if (r.to !== 1) begin miscompares++; $display("FAIL timeout_pulse got %0d exp 1", r.to); end
      if (r.dec !== 0) begin miscompares++; $display("FAIL timeout_decode_err got %0d exp 0", r.dec); end
      run_txn(48'h1_0800_0040, 1'b0, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D, 1'b0, r);
      go_idle(1);
      vectors += 3;
      if (r.lat !== 4) begin miscompares++; $display("FAIL after_timeout_lat got %0d exp 4", r.lat); end
      if (r.rdata !== 32'h0BAD_F00D || r.err !== 1'b0) begin miscompares++; $display("FAIL after_timeout_rsp got rdata=%h err=%b exp 0badf00d 0", r.rdata, r.err); end
      if (r.to !== 0) begin miscompares++; $display("FAIL after_timeout_pulse got %0d exp 0", r.to); end
   endtask

   task automatic test_ready_at_limit();
      txn_res_t r;
      run_txn(48'h1_0000_0200, 1'b0, 32'h0, 4'h0, 0, T - 1, 32'h7777_8888, 1'b0, r);
      go_idle(1);
      vectors += 4;
      if (r.lat !== T + 1) begin miscompares++; $display("FAIL limit_lat got %0d exp %0d", r.lat, T + 1); end
      if (r.rdata !== 32'h7777_8888) begin miscompares++; $display("FAIL limit_rdata got %h exp 77778888", r.rdata); end
      if (r.err !== 1'b0) begin miscompares++; $display("FAIL limit_err got %b exp 0", r.err); end
      if (r.to !== 0) begin miscompares++; $display("FAIL limit_timeout got %0d exp 0", r.to); end
   endtask

   task automatic test_reset_mid();
      txn_res_t r;
      logic     seen;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         slv_req.addr = 48'h1_0000_0020; slv_req.write = 1'b0; slv_req.wdata = '0;
         slv_req.wstrb = '0; slv_req.valid = 1'b1; mst_rsp = '0;
         @(negedge clk);
         if (mst_req[0].valid === 1'b1) seen = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; slv_req = '0;
      @(negedge clk);
      vectors += 3;
      if (seen !== 1'b1) begin miscompares++; $display("FAIL rst_mid_fwd got valid=%b exp 1", seen); end
      if (mst_req[0].valid !== 1'b0 || mst_req[1].valid !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid_valids got %b%b exp 00", mst_req[1].valid, mst_req[0].valid);
      end
      if (slv_rsp.ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready got %b exp 0", slv_rsp.ready); end
      run_txn(48'h1_0000_0030, 1'b0, 32'h0, 4'h0, 0, 0, 32'h4242_4242, 1'b0, r);
      go_idle(1);
      vectors += 2;
      if (r.lat !== 2) begin miscompares++; $display("FAIL rst_mid_next_lat got %0d exp 2", r.lat); end
      if (r.rdata !== 32'h4242_4242) begin miscompares++; $display("FAIL rst_mid_next_rdata got %h exp 42424242", r.rdata); end
   endtask

   task automatic test_rule_edge();
      txn_res_t r;
      addr_map[1].idx = 5;
      run_txn(48'h1_0800_0004, 1'b0, 32'h0, 4'h0, -1, 0, 32'h1, 1'b0, r);
      go_idle(1);
      vectors += 2;
      if (r.err !== 1'b1 || r.lat !== 1) begin miscompares++; $display("FAIL bad_idx_rsp got err=%b lat=%0d exp err=1 lat=1", r.err, r.lat); end
      if (r.dec !== 1 || r.v0 + r.v1 !== 0) begin miscompares++; $display("FAIL bad_idx_decode got dec=%0d vld=%0d exp 1 0", r.dec, r.v0 + r.v1); end
      addr_map[1].idx = 1; addr_map[1].start_addr = 48'h1_0000_0000;
      run_txn(48'h1_0000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 32'h2, 1'b0, r);
      go_idle(1);
      vectors += 1;
      if (r.v0 !== 1 || r.v1 !== 0) begin miscompares++; $display("FAIL overlap_lowest got v0=%0d v1=%0d exp 1 0", r.v0, r.v1); end
      set_default_map();
   endtask

   task automatic test_random();
      txn_res_t    r, e;
      logic [47:0] a;
      logic        wr, serr;
      logic [31:0] wd, srd;
      logic [3:0]  ws;
      int          stall, tgt;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0: a = 48'h1_0000_0000 + 48'($urandom_range(0, 32'h07FF_FFFF));
            1: a = 48'h1_0800_0000 + 48'($urandom_range(0, 32'h07FF_FFFF));
            2: a = 48'h1_1000_0000;
            3: a = 48'h0_FFFF_FFFF;
            4: a = 48'h1_07FF_FFFF;
            default: a = {16'($urandom), 32'($urandom)};
         endcase
         wr = 1'($urandom); wd = $urandom; ws = 4'($urandom);
         srd = $urandom; serr = ($urandom_range(0, 3) == 0);
         stall = $urandom_range(0, 20);
         tgt = model_target(a);
         e = model_txn(tgt, wr, stall, srd, serr);
         run_txn(a, wr, wd, ws, tgt, stall, srd, serr, r);
         vectors += 8;
         if (r.lat !== e.lat) begin miscompares++; $display("FAIL rnd%0d_lat got %0d exp %0d", i, r.lat, e.lat); end
         if (r.rdata !== e.rdata) begin miscompares++; $display("FAIL rnd%0d_rdata got %h exp %h", i, r.rdata, e.rdata); end
         if (r.err !== e.err) begin miscompares++; $display("FAIL rnd%0d_err got %b exp %b", i, r.err, e.err); end
         if (r.v0 !== e.v0) begin miscompares++; $display("FAIL rnd%0d_v0 got %0d exp %0d", i, r.v0, e.v0); end
         if (r.v1 !== e.v1) begin miscompares++; $display("FAIL rnd%0d_v1 got %0d exp %0d", i, r.v1, e.v1); end
         if (r.dec !== e.dec) begin miscompares++; $display("FAIL rnd%0d_decode_err got %0d exp %0d", i, r.dec, e.dec); end
         if (r.to !== e.to) begin miscompares++; $display("FAIL rnd%0d_timeout got %0d exp %0d", i, r.to, e.to); end
         if (r.bad !== 0) begin miscompares++; $display("FAIL rnd%0d_payload got %0d bad cycles exp 0", i, r.bad); end
      end
      go_idle(1);
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_stall();
      test_miss();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid();
      test_rule_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
